// File: rtl/ex_muldiv_if.sv
// Issue/result bundle between the EX stage and the mult/div unit.
// HI/LO are the architectural registers held inside the unit.
interface ex_muldiv_if;
  logic        I_start;
  logic [1:0]  I_op;
  logic [31:0] I_O1;
  logic [31:0] I_O2;
  logic        I_mthi;
  logic        I_mtlo;
  logic        O_busy;
  logic        O_done;
  logic [31:0] O_HI;
  logic [31:0] O_LO;

  modport master (
    output I_start, I_op, I_O1, I_O2, I_mthi, I_mtlo,
    input  O_busy, O_done, O_HI, O_LO
  );

  modport slave (
    input  I_start, I_op, I_O1, I_O2, I_mthi, I_mtlo,
    output O_busy, O_done, O_HI, O_LO
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative 32-cycle multiply/divide unit with architectural HI/LO registers.
// Works on unsigned magnitudes and fixes signs in a final FIX cycle.
module ex_muldiv (
  input logic         clk,
  input logic         rst_n,
  ex_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        isDiv_q, isDiv_d;
  logic        divZero_q, divZero_d;
  logic        negQ_q, negQ_d;
  logic        negR_q, negR_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] rsRaw_q, rsRaw_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        isSignedIn;
  logic [31:0] magA, magB;
  logic [32:0] multSum, remShift, remDiff;
  logic [63:0] prodFix;
  logic [31:0] quotFix, remFix;

  // Magnitudes stay 32-bit unsigned so that -2^31 needs no special case.
  assign isSignedIn = ~bus.I_op[0];
  assign magA = (isSignedIn && bus.I_O1[31]) ? (~bus.I_O1 + 32'd1) : bus.I_O1;
  assign magB = (isSignedIn && bus.I_O2[31]) ? (~bus.I_O2 + 32'd1) : bus.I_O2;

  // acc holds {partial product, remaining multiplier} or {remainder, quotient}.
  assign multSum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvsr_q} : 33'd0);
  assign remShift = acc_q[63:31];
  assign remDiff  = remShift - {1'b0, dvsr_q};

  assign prodFix = negQ_q ? (~acc_q + 64'd1) : acc_q;
  assign quotFix = negQ_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign remFix  = negR_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    isDiv_d   = isDiv_q;
    divZero_d = divZero_q;
    negQ_d    = negQ_q;
    negR_d    = negR_q;
    dvsr_d    = dvsr_q;
    acc_d     = acc_q;
    rsRaw_d   = rsRaw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.I_start) begin
          isDiv_d   = bus.I_op[1];
          rsRaw_d   = bus.I_O1;
          cnt_d     = 5'd0;
          negQ_d    = isSignedIn & (bus.I_O1[31] ^ bus.I_O2[31]);
          negR_d    = isSignedIn & bus.I_O1[31];
          if (bus.I_op[1]) begin
            dvsr_d    = magB;
            acc_d     = {32'd0, magA};
            divZero_d = (bus.I_O2 == 32'd0);
            state_d   = (bus.I_O2 == 32'd0) ? FIX : RUN;
          end else begin
            dvsr_d    = magA;
            acc_d     = {32'd0, magB};
            divZero_d = 1'b0;
            state_d   = RUN;
          end
        end else begin
          if (bus.I_mthi) hi_d = bus.I_O1;
          if (bus.I_mtlo) lo_d = bus.I_O1;
        end
      end
      RUN: begin
        if (isDiv_q) begin
          if (!remDiff[32]) acc_d = {remDiff[31:0], acc_q[30:0], 1'b1};
          else              acc_d = {remShift[31:0], acc_q[30:0], 1'b0};
        end else begin
          acc_d = {multSum, acc_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (divZero_q) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = rsRaw_q;
        end else if (isDiv_q) begin
          lo_d = quotFix;
          hi_d = remFix;
        end else begin
          hi_d = prodFix[63:32];
          lo_d = prodFix[31:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      isDiv_q   <= 1'b0;
      divZero_q <= 1'b0;
      negQ_q    <= 1'b0;
      negR_q    <= 1'b0;
      dvsr_q    <= 32'd0;
      acc_q     <= 64'd0;
      rsRaw_q   <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      isDiv_q   <= isDiv_d;
      divZero_q <= divZero_d;
      negQ_q    <= negQ_d;
      negR_q    <= negR_d;
      dvsr_q    <= dvsr_d;
      acc_q     <= acc_d;
      rsRaw_q   <= rsRaw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.O_busy = (state_q != IDLE);
  assign bus.O_done = done_q;
  assign bus.O_HI   = hi_q;
  assign bus.O_LO   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes expected {HI,LO},
// a negedge monitor pops and compares on every O_done pulse.
module tb_ex_muldiv;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  ex_muldiv_if bus();

  ex_muldiv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] expQ[$];
  logic [63:0] expPop;
  logic [31:0] hiModel = 32'd0;
  logic [31:0] loModel = 32'd0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.O_done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected O_done", 32'd1, 32'd0);
      end else begin
        expPop = expQ.pop_front();
        checkOutput("HI result", bus.O_HI, expPop[63:32]);
        checkOutput("LO result", bus.O_LO, expPop[31:0]);
      end
    end
  end

  task automatic waitDone(input bit interfere, input int expLat);
    int lat = 0;
    int busyCnt = 0;
    bit seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      if (lat == 0) begin
        checkOutput("HI held after E0", bus.O_HI, hiModel);
        checkOutput("LO held after E0", bus.O_LO, loModel);
      end
      if (interfere && lat == 11) checkOutput("HI after mthi while busy", bus.O_HI, hiModel);
      if (bus.O_busy) busyCnt++;
      if (bus.O_done) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        lat++;
        if (interfere && lat == 9) begin
          #1;
          bus.I_start = 1'b1;
          bus.I_op    = 2'b11;
          bus.I_O1    = 32'd7;
          bus.I_O2    = 32'd9;
          bus.I_mthi  = 1'b1;
        end
        if (interfere && lat == 10) begin
          #1;
          bus.I_start = 1'b0;
          bus.I_mthi  = 1'b0;
        end
      end
    end
    if (!seen) checkOutput("O_done timeout", 32'd0, 32'd1);
    checkOutput("latency edges after E0", lat, expLat);
    checkOutput("busy cycles", busyCnt, expLat);
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] mv, input logic [31:0] expHi,
                               input logic [31:0] expLo, input int expLat, input bit interfere);
    @(posedge clk);
    #1;
    bus.I_start = 1'b1;
    bus.I_op    = op;
    bus.I_O1    = a;
    bus.I_O2    = b;
    bus.I_mthi  = mv[1];
    bus.I_mtlo  = mv[0];
    expQ.push_back({expHi, expLo});
    @(posedge clk);
    #1;
    bus.I_start = 1'b0;
    bus.I_mthi  = 1'b0;
    bus.I_mtlo  = 1'b0;
    waitDone(interfere, expLat);
    hiModel = expHi;
    loModel = expLo;
  endtask

  task automatic doMove(input bit toHi, input bit toLo, input logic [31:0] val);
    @(posedge clk);
    #1;
    bus.I_O1   = val;
    bus.I_mthi = toHi;
    bus.I_mtlo = toLo;
    @(posedge clk);
    #1;
    bus.I_mthi = 1'b0;
    bus.I_mtlo = 1'b0;
    if (toHi) hiModel = val;
    if (toLo) loModel = val;
    @(negedge clk);
    checkOutput("HI after move", bus.O_HI, hiModel);
    checkOutput("LO after move", bus.O_LO, loModel);
  endtask

  initial begin
    bus.I_start = 1'b0;
    bus.I_op    = 2'b00;
    bus.I_O1    = 32'd0;
    bus.I_O2    = 32'd0;
    bus.I_mthi  = 1'b0;
    bus.I_mtlo  = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", {31'd0, bus.O_busy}, 32'd0);
    checkOutput("reset done", {31'd0, bus.O_done}, 32'd0);
    checkOutput("reset HI", bus.O_HI, 32'd0);
    checkOutput("reset LO", bus.O_LO, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    doMove(1'b1, 1'b0, 32'hAAAA_5555);
    doMove(1'b0, 1'b1, 32'h0F0F_0F0F);
    doMove(1'b1, 1'b1, 32'h1234_5678);

    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd5,        2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, 1'b0);
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2,        2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h0000_0000, 32'h8000_0000, 33, 1'b0);
    applyStimulus(2'b11, 32'h0000_1234, 32'd0,        2'b00, 32'h0000_1234, 32'hFFFF_FFFF, 1,  1'b0);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd0,        2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1,  1'b0);
    applyStimulus(2'b11, 32'd100,       32'd7,        2'b00, 32'd2,         32'd14,        33, 1'b0);
    applyStimulus(2'b10, 32'd7,         32'hFFFF_FFFE, 2'b00, 32'd1,        32'hFFFF_FFFD, 33, 1'b0);
    applyStimulus(2'b00, 32'h8000_0000, 32'h8000_0000, 2'b00, 32'h4000_0000, 32'h0000_0000, 33, 1'b0);
    applyStimulus(2'b01, 32'hDEAD_BEEF, 32'd2,        2'b01, 32'h0000_0001, 32'hBD5B_7DDE, 33, 1'b0);
    applyStimulus(2'b00, 32'h0001_0000, 32'h0001_0000, 2'b00, 32'h0000_0001, 32'h0000_0000, 33, 1'b1);

    // Abort a divide mid-flight; no expectation is queued for it.
    @(posedge clk);
    #1;
    bus.I_start = 1'b1;
    bus.I_op    = 2'b10;
    bus.I_O1    = 32'd100;
    bus.I_O2    = 32'd7;
    @(posedge clk);
    #1 bus.I_start = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    hiModel = 32'd0;
    loModel = 32'd0;
    checkOutput("abort busy", {31'd0, bus.O_busy}, 32'd0);
    checkOutput("abort done", {31'd0, bus.O_done}, 32'd0);
    checkOutput("abort HI", bus.O_HI, 32'd0);
    checkOutput("abort LO", bus.O_LO, 32'd0);
    repeat (3) @(posedge clk);

    // Release reset while I_start is already high.
    #1;
    bus.I_start = 1'b1;
    bus.I_op    = 2'b01;
    bus.I_O1    = 32'd3;
    bus.I_O2    = 32'd4;
    expQ.push_back({32'd0, 32'd12});
    #2 rst_n = 1'b1;
    #1 checkOutput("busy before first edge", {31'd0, bus.O_busy}, 32'd0);
    @(posedge clk);
    #1 bus.I_start = 1'b0;
    waitDone(1'b0, 33);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard drained", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port I_start, input, 1 bit: EX-stage mult/div issue, qualified by the ID/EX stage outputs.
REQ-004 SHALL have port I_op, input, 2 bits: 00 mult, 01 multu, 10 div, 11 divu.
REQ-005 SHALL have port I_O1, input, 32 bits: rs operand (multiplicand or dividend; also the mthi/mtlo source).
REQ-006 SHALL have port I_O2, input, 32 bits: rt operand (multiplier or divisor).
REQ-007 SHALL have ports I_mthi and I_mtlo, input, 1 bit each: write I_O1 into HI or LO.
REQ-008 SHALL have port O_busy, output, 1 bit: operation in flight; stall request to IF/ID and ID/EX.
REQ-009 SHALL have port O_done, output, 1 bit: one-cycle pulse, HI/LO just updated.
REQ-010 SHALL have ports O_HI and O_LO, output, 32 bits each: architectural HI/LO registers.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and FIX; O_busy SHALL be 1 in every state except IDLE.
REQ-012 In IDLE with I_start=1, the block SHALL latch operands and I_op on edge E0; a nonzero divisor, or any mult, SHALL go to RUN with the iteration counter at 0.
REQ-013 In RUN, each edge SHALL perform one iteration: shift-add for mult, restoring shift-subtract for div.
REQ-014 After 32 iterations (edges E1..E32) the FSM SHALL go to FIX; at E33, HI/LO SHALL be written and the FSM SHALL return to IDLE.
REQ-015 O_done SHALL be 1 only in the cycle following the HI/LO write (after E33); total latency from start is 34 edges.
REQ-016 Signed ops SHALL compute on magnitudes, with sign correction applied in FIX.
REQ-017 Signed mult SHALL negate the 64-bit product when the operand signs differ.
REQ-018 Signed div SHALL take the quotient sign as sign(rs) XOR sign(rt) and the remainder sign as sign(rs).
REQ-019 Mult SHALL place the product as {HI,LO}; div SHALL place the quotient in LO and the remainder in HI.
REQ-020 Magnitudes SHALL be 32-bit unsigned, so that -2^31 is handled: 0x80000000 / 0xFFFFFFFF (signed) SHALL give LO=0x80000000, HI=0.
REQ-021 Div with divisor 0 SHALL go from E0 directly to FIX, then write LO=0xFFFFFFFF and HI=dividend (raw I_O1) at E1; O_done SHALL follow E1.
REQ-022 I_start while O_busy=1 SHALL be ignored; latched operands SHALL be unaffected.
REQ-023 I_mthi/I_mtlo in IDLE SHALL write I_O1 to HI/LO at the next edge; both asserted SHALL write both.
REQ-024 I_mthi/I_mtlo while O_busy=1 SHALL be ignored.
REQ-025 I_start together with I_mthi/I_mtlo in IDLE: start SHALL win, and the move SHALL be dropped.
REQ-026 O_HI/O_LO SHALL hold their value at all times except on the write edge; no partial results SHALL be visible.
REQ-027 An undefined I_op value SHALL NOT exist: all 4 codes are legal.

Reset
REQ-028 On rst_n=0, asynchronously: state IDLE, counter 0, O_busy=0, O_done=0, O_HI=0, O_LO=0, and all internal operand/accumulator registers 0.
REQ-029 Reset mid-operation SHALL abort the operation with no HI/LO write; the first I_start after rst_n rises SHALL behave as from cold.
REQ-030 A reset release with I_start=1 SHALL NOT start an operation until the first rising edge with rst_n=1.

Verification
REQ-031 mult, rs=0xFFFFFFFD (-3), rt=5 -> O_busy=1 for 33 cycles; O_done after E33; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-032 multu, 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, O_done one cycle.
REQ-033 div, -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 divu, rs=0x1234, rt=0 -> O_done after E1; LO=0xFFFFFFFF, HI=0x1234.
REQ-035 Start mult, reassert I_start with new operands plus I_mthi at E10 -> ignored; the original result is written at E33.
REQ-036 Start div; pull rst_n low at E15 -> immediate IDLE, O_busy=0, HI=LO=0, no O_done; new multu 3x4 -> HI=0, LO=12.
